// File: rtl/shift_chain_loader.sv
// shift_chain_loader: shifts a parallel word bit-serially into an external
// flip-flop chain, reads the bits back at the chain tap into a parallel word
// and reports whether the word survived the trip through the chain.
module shift_chain_loader #(
  parameter int   DEPTH = 4,
  parameter int   WIDTH = 8,
  parameter logic FILL  = 1'b0
) (
  input  logic             N14,
  input  logic             N15,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             abort,
  output logic             sdo,
  output logic             shift_en,
  input  logic             sdi,
  output logic             cap_valid,
  output logic [WIDTH-1:0] cap_data,
  output logic             cap_match,
  output logic             busy
);

  // One shift per word bit plus DEPTH-1 flush shifts to push the last bit out.
  localparam int N  = WIDTH + DEPTH - 1;
  localparam int KW = $clog2(N + 1);

  localparam logic [KW-1:0] K_LAST  = KW'(N - 1);
  localparam logic [KW-1:0] K_WIDTH = KW'(WIDTH);
  localparam logic [KW:0]   K_DEPTH = (KW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] capt_q, capt_d;
  logic             sdo_q, sdo_d;
  logic             shift_en_q, shift_en_d;
  logic             load_ready_q, load_ready_d;
  logic             busy_q, busy_d;
  logic             cap_valid_q, cap_valid_d;
  logic [WIDTH-1:0] cap_data_q, cap_data_d;
  logic             cap_match_q, cap_match_d;

  logic [KW-1:0]    k_inc;
  logic             in_window;
  logic             next_bit;
  logic [WIDTH-1:0] capt_sampled;

  // Next-state and next-output logic; the tap is sampled only once the first word bit has reached it.
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    hold_d       = hold_q;
    capt_d       = capt_q;
    sdo_d        = sdo_q;
    shift_en_d   = 1'b0;
    load_ready_d = load_ready_q;
    busy_d       = busy_q;
    cap_valid_d  = 1'b0;
    cap_data_d   = cap_data_q;
    cap_match_d  = cap_match_q;

    k_inc     = k_q + KW'(1);
    next_bit  = (k_inc < K_WIDTH) ? |(hold_q & (WIDTH'(1) << k_inc)) : FILL;
    in_window = ({1'b0, k_q} + (KW + 1)'(1)) >= K_DEPTH;
    capt_sampled = in_window ? ((capt_q >> 1) | (WIDTH'(sdi) << (WIDTH - 1)))
                             : capt_q;

    if (abort && (state_q != IDLE)) begin
      state_d      = IDLE;
      k_d          = '0;
      load_ready_d = 1'b1;
      busy_d       = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_valid && load_ready_q) begin
            hold_d       = load_data;
            capt_d       = '0;
            k_d          = '0;
            sdo_d        = load_data[0];
            shift_en_d   = 1'b1;
            load_ready_d = 1'b0;
            busy_d       = 1'b1;
            state_d      = SHIFT;
          end
        end
        SHIFT: begin
          state_d = GAP;
        end
        GAP: begin
          capt_d = capt_sampled;
          if (k_q == K_LAST) begin
            cap_valid_d = 1'b1;
            cap_data_d  = capt_sampled;
            cap_match_d = (capt_sampled == hold_q);
            state_d     = DONE;
          end else begin
            k_d        = k_inc;
            sdo_d      = next_bit;
            shift_en_d = 1'b1;
            state_d    = SHIFT;
          end
        end
        DONE: begin
          k_d          = '0;
          load_ready_d = 1'b1;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and output registers, cleared immediately on reset.
  always_ff @(posedge N14 or posedge N15) begin
    if (N15) begin
      state_q      <= IDLE;
      k_q          <= '0;
      hold_q       <= '0;
      capt_q       <= '0;
      sdo_q        <= 1'b0;
      shift_en_q   <= 1'b0;
      load_ready_q <= 1'b1;
      busy_q       <= 1'b0;
      cap_valid_q  <= 1'b0;
      cap_data_q   <= '0;
      cap_match_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      hold_q       <= hold_d;
      capt_q       <= capt_d;
      sdo_q        <= sdo_d;
      shift_en_q   <= shift_en_d;
      load_ready_q <= load_ready_d;
      busy_q       <= busy_d;
      cap_valid_q  <= cap_valid_d;
      cap_data_q   <= cap_data_d;
      cap_match_q  <= cap_match_d;
    end
  end

  assign load_ready = load_ready_q;
  assign busy       = busy_q;
  assign sdo        = sdo_q;
  assign shift_en   = shift_en_q;
  assign cap_valid  = cap_valid_q;
  assign cap_data   = cap_data_q;
  assign cap_match  = cap_match_q;

endmodule

// File: tb/tb_shift_chain_loader.sv
// tb_shift_chain_loader: drives two loaders (default 4x8 and 1x3) into
// behavioural chain models and scores every captured word and serial bit.
module tb_shift_chain_loader;

  localparam int DEPTH   = 4;
  localparam int WIDTH   = 8;
  localparam int NSH     = WIDTH + DEPTH - 1;
  localparam int DEPTH_B = 1;
  localparam int WIDTH_B = 3;
  localparam int NSH_B   = WIDTH_B + DEPTH_B - 1;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             match;
    int               cycle;
  } exp_t;

  typedef struct {
    logic [WIDTH_B-1:0] data;
    int                 cycle;
  } exp_b_t;

  logic N14 = 1'b0;
  logic N15 = 1'b1;

  logic             load_valid_a = 1'b0;
  logic [WIDTH-1:0] load_data_a  = '0;
  logic             abort_a      = 1'b0;
  logic             load_ready_a, sdo_a, shift_en_a, sdi_a;
  logic             cap_valid_a, cap_match_a, busy_a;
  logic [WIDTH-1:0] cap_data_a;

  logic               load_valid_b = 1'b0;
  logic [WIDTH_B-1:0] load_data_b  = '0;
  logic               abort_b      = 1'b0;
  logic               load_ready_b, sdo_b, shift_en_b, sdi_b;
  logic               cap_valid_b, cap_match_b, busy_b;
  logic [WIDTH_B-1:0] cap_data_b;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  exp_t   capQ[$];
  logic   sdoQ[$];
  exp_b_t capQB[$];
  exp_t   got;
  exp_b_t gotB;

  logic [WIDTH-1:0] lastData  = '0;
  logic             lastMatch = 1'b0;

  logic [DEPTH-1:0] chainA = '0;
  logic [DEPTH-1:0] viewA;
  logic             stuckA = 1'b0;
  logic             chainB = 1'b0;

  logic [WIDTH-1:0]   w;
  logic [WIDTH_B-1:0] wb;
  int                 t0;

  shift_chain_loader #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FILL(1'b0)) dutA (
    .N14(N14), .N15(N15),
    .load_valid(load_valid_a), .load_data(load_data_a), .load_ready(load_ready_a),
    .abort(abort_a), .sdo(sdo_a), .shift_en(shift_en_a), .sdi(sdi_a),
    .cap_valid(cap_valid_a), .cap_data(cap_data_a), .cap_match(cap_match_a),
    .busy(busy_a)
  );

  shift_chain_loader #(.DEPTH(DEPTH_B), .WIDTH(WIDTH_B), .FILL(1'b0)) dutB (
    .N14(N14), .N15(N15),
    .load_valid(load_valid_b), .load_data(load_data_b), .load_ready(load_ready_b),
    .abort(abort_b), .sdo(sdo_b), .shift_en(shift_en_b), .sdi(sdi_b),
    .cap_valid(cap_valid_b), .cap_data(cap_data_b), .cap_match(cap_match_b),
    .busy(busy_b)
  );

  always #5 N14 = ~N14;

  // Cycle counter used to timestamp expected capture pulses.
  always @(posedge N14) cyc <= cyc + 1;

  // Chain models: stage 1 takes sdo, the tap is the last stage; stage 2 may be stuck at 1.
  assign viewA = chainA | (stuckA ? DEPTH'(2) : DEPTH'(0));
  assign sdi_a = viewA[DEPTH-1];
  assign sdi_b = chainB;

  always @(posedge N14) begin
    if (shift_en_a) chainA <= {viewA[DEPTH-2:0], sdo_a};
    if (shift_en_b) chainB <= sdo_b;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference: a healthy chain returns the word; a stuck stage forces every returned bit to 1.
  task automatic pushExpect(input logic [WIDTH-1:0] word, input logic stuck);
    exp_t e;
    logic [WIDTH-1:0] seen;
    seen    = stuck ? '1 : word;
    e.data  = seen;
    e.match = (seen == word);
    e.cycle = cyc + 2 * NSH + 1;
    capQ.push_back(e);
    for (int i = 0; i < NSH; i++) sdoQ.push_back((i < WIDTH) ? word[i] : 1'b0);
  endtask

  // Called at a falling edge while the loader is idle; leaves one falling edge later.
  task automatic applyStimulus(input logic [WIDTH-1:0] word, input logic stuck,
                               input logic abortIdle);
    stuckA       = stuck;
    load_data_a  = word;
    load_valid_a = 1'b1;
    abort_a      = abortIdle;
    checkOutput("load_ready idle", load_ready_a, 1);
    checkOutput("busy idle", busy_a, 0);
    pushExpect(word, stuck);
    @(negedge N14);
    load_valid_a = 1'b0;
    abort_a      = 1'b0;
    checkOutput("busy after accept", busy_a, 1);
    checkOutput("load_ready after accept", load_ready_a, 0);
  endtask

  task automatic runLoad(input logic [WIDTH-1:0] word, input logic stuck,
                         input logic abortIdle);
    applyStimulus(word, stuck, abortIdle);
    repeat (2 * NSH + 1) @(negedge N14);
    checkOutput("load_ready returns", load_ready_a, 1);
  endtask

  task automatic checkResetValues();
    checkOutput("rst load_ready", load_ready_a, 1);
    checkOutput("rst busy", busy_a, 0);
    checkOutput("rst sdo", sdo_a, 0);
    checkOutput("rst shift_en", shift_en_a, 0);
    checkOutput("rst cap_valid", cap_valid_a, 0);
    checkOutput("rst cap_data", cap_data_a, 0);
    checkOutput("rst cap_match", cap_match_a, 0);
  endtask

  // Monitor A: every strobe consumes one expected serial bit, every capture one expected word.
  always @(negedge N14) begin
    if (!N15) begin
      if (shift_en_a) begin
        if (sdoQ.size() == 0) checkOutput("unexpected shift_en", shift_en_a, 0);
        else checkOutput("sdo bit", sdo_a, sdoQ.pop_front());
      end
      if (cap_valid_a) begin
        if (capQ.size() == 0) checkOutput("unexpected cap_valid", cap_valid_a, 0);
        else begin
          got = capQ.pop_front();
          checkOutput("cap_valid cycle", cyc, got.cycle);
          checkOutput("cap_data", cap_data_a, got.data);
          checkOutput("cap_match", cap_match_a, got.match);
          lastData  = got.data;
          lastMatch = got.match;
        end
      end
    end
  end

  // Monitor B: scores captures from the single-stage loader.
  always @(negedge N14) begin
    if (!N15 && cap_valid_b) begin
      if (capQB.size() == 0) checkOutput("B unexpected cap_valid", cap_valid_b, 0);
      else begin
        gotB = capQB.pop_front();
        checkOutput("B cap_valid cycle", cyc, gotB.cycle);
        checkOutput("B cap_data", cap_data_b, gotB.data);
        checkOutput("B cap_match", cap_match_b, 1);
      end
    end
  end

  // Main sequence: reset, directed loads, abort, mid-load reset, streaming, random, then the 1x3 loader.
  initial begin
    repeat (3) @(negedge N14);
    checkResetValues();
    #1 N15 = 1'b0;

    runLoad(8'hA5, 1'b0, 1'b0);
    runLoad(8'h00, 1'b1, 1'b0);
    runLoad(8'h5A, 1'b0, 1'b0);

    applyStimulus(8'hC3, 1'b0, 1'b0);
    repeat (9) @(negedge N14);
    abort_a = 1'b1;
    @(negedge N14);
    abort_a = 1'b0;
    void'(capQ.pop_back());
    sdoQ.delete();
    checkOutput("abort load_ready", load_ready_a, 1);
    checkOutput("abort busy", busy_a, 0);
    checkOutput("abort keeps cap_data", cap_data_a, lastData);
    checkOutput("abort keeps cap_match", cap_match_a, lastMatch);
    runLoad(8'h96, 1'b0, 1'b0);

    applyStimulus(8'h77, 1'b0, 1'b0);
    repeat (6) @(negedge N14);
    #1;
    void'(capQ.pop_back());
    sdoQ.delete();
    N15 = 1'b1;
    #1;
    checkResetValues();
    repeat (3) begin
      @(negedge N14);
      checkOutput("shift_en held in reset", shift_en_a, 0);
    end
    lastData  = '0;
    lastMatch = 1'b0;
    #1 N15 = 1'b0;
    runLoad(8'h3C, 1'b0, 1'b0);

    t0 = cyc;
    load_valid_a = 1'b1;
    stuckA = 1'b0;
    for (int i = 0; i < 4; i++) begin
      load_data_a = (i % 2 == 0) ? 8'h0F : 8'hF0;
      checkOutput("stream load_ready", load_ready_a, 1);
      checkOutput("stream accept spacing", cyc - t0, i * (2 * NSH + 2));
      pushExpect(load_data_a, 1'b0);
      repeat (12) @(negedge N14);
      checkOutput("stream busy", busy_a, 1);
      checkOutput("stream ignored load_ready", load_ready_a, 0);
      repeat (2 * NSH + 2 - 12) @(negedge N14);
    end
    load_valid_a = 1'b0;
    checkOutput("stream final load_ready", load_ready_a, 1);
    @(negedge N14);

    for (int i = 0; i < 6; i++) begin
      w = WIDTH'($urandom);
      runLoad(w, ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
    end

    for (int i = 0; i < 3; i++) begin
      wb = (i == 0) ? 3'b110 : WIDTH_B'($urandom);
      load_data_b  = wb;
      load_valid_b = 1'b1;
      checkOutput("B load_ready idle", load_ready_b, 1);
      capQB.push_back('{data: wb, cycle: cyc + 2 * NSH_B + 1});
      @(negedge N14);
      load_valid_b = 1'b0;
      checkOutput("B busy after accept", busy_b, 1);
      repeat (2 * NSH_B + 1) @(negedge N14);
      checkOutput("B load_ready returns", load_ready_b, 1);
    end

    repeat (4) @(negedge N14);
    checkOutput("A captures outstanding", capQ.size(), 0);
    checkOutput("A serial bits outstanding", sdoQ.size(), 0);
    checkOutput("B captures outstanding", capQB.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
